// File: rtl/dmem_responder.sv
// Data-memory port target: 3840-byte RAM below RAM_TOP plus an MMIO page with
// GPIO, a down-counting timer with interrupt, and a small console transmit FIFO.
module dmem_responder #(
    parameter logic [11:0] RAM_TOP   = 12'hEFF,
    parameter int unsigned TXF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [11:0] d_mem_addr,
    input  logic        d_mem_en,
    input  logic        d_mem_rd,
    input  logic        d_mem_wr,
    input  logic [7:0]  d_mem_data_out,
    output logic [7:0]  d_mem_data_in,
    output logic [7:0]  gpio_out,
    output logic        timer_irq,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned PW      = (TXF_DEPTH > 1) ? $clog2(TXF_DEPTH) : 1;
    localparam logic [3:0]  DEPTH_C = 4'(TXF_DEPTH);

    localparam logic [11:0] A_GPIO    = 12'hF00;
    localparam logic [11:0] A_TCTRL   = 12'hF01;
    localparam logic [11:0] A_TRELOAD = 12'hF02;
    localparam logic [11:0] A_TCOUNT  = 12'hF03;
    localparam logic [11:0] A_TXDATA  = 12'hF04;
    localparam logic [11:0] A_TXSTAT  = 12'hF05;

    logic [7:0]    ram [0:RAM_TOP];

    logic [7:0]    gpio;
    logic          t_en, t_auto, t_pend;
    logic [7:0]    t_reload, t_count;
    logic [7:0]    txf_mem [TXF_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    tx_count;
    logic          tx_ovf;

    logic wr_acc, expire, full, push_req, push, pop;
    logic [7:0] rdata;

    assign wr_acc   = d_mem_en & d_mem_wr;
    assign expire   = t_en && (t_count == '0);
    assign full     = (tx_count == DEPTH_C);
    assign push_req = wr_acc && (d_mem_addr == A_TXDATA);
    assign push     = push_req && !full;
    assign tx_valid = (tx_count != '0);
    assign pop      = tx_valid && tx_ready;
    assign tx_data  = tx_valid ? txf_mem[rd_ptr] : '0;

    assign gpio_out      = gpio;
    assign timer_irq     = t_pend;
    assign d_mem_data_in = rdata;

    always_ff @(posedge clk) begin
        if (wr_acc && (d_mem_addr <= RAM_TOP))
            ram[d_mem_addr] <= d_mem_data_out;
    end

    // CPU register writes come after the timer step so they override it.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            gpio     <= '0;
            t_en     <= 1'b0;
            t_auto   <= 1'b0;
            t_pend   <= 1'b0;
            t_reload <= '0;
            t_count  <= '0;
        end else begin
            if (t_en) begin
                if (t_count != '0)
                    t_count <= t_count - 8'd1;
                else if (t_auto)
                    t_count <= t_reload;
                else
                    t_en <= 1'b0;
            end
            if (expire)
                t_pend <= 1'b1;
            else if (wr_acc && (d_mem_addr == A_TCTRL) && d_mem_data_out[2])
                t_pend <= 1'b0;
            if (wr_acc) begin
                case (d_mem_addr)
                    A_GPIO:    gpio <= d_mem_data_out;
                    A_TCTRL: begin
                        t_en   <= d_mem_data_out[0];
                        t_auto <= d_mem_data_out[1];
                    end
                    A_TRELOAD: t_reload <= d_mem_data_out;
                    A_TCOUNT:  t_count  <= d_mem_data_out;
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int unsigned i = 0; i < TXF_DEPTH; i++)
                txf_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
            tx_ovf   <= 1'b0;
        end else begin
            if (push) begin
                txf_mem[wr_ptr] <= d_mem_data_out;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                tx_count <= tx_count + 4'd1;
            else if (!push && pop)
                tx_count <= tx_count - 4'd1;
            if (push_req && full)
                tx_ovf <= 1'b1;
            else if (wr_acc && (d_mem_addr == A_TXSTAT) && d_mem_data_out[2])
                tx_ovf <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (d_mem_en && d_mem_rd) begin
            if (d_mem_addr <= RAM_TOP) begin
                rdata = ram[d_mem_addr];
            end else begin
                case (d_mem_addr)
                    A_GPIO:    rdata = gpio;
                    A_TCTRL:   rdata = {5'b0, t_pend, t_auto, t_en};
                    A_TRELOAD: rdata = t_reload;
                    A_TCOUNT:  rdata = t_count;
                    A_TXSTAT:  rdata = {2'b0, tx_count[2:0], tx_ovf, !tx_valid, full};
                    default:   rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic, all checked
// against a queue/array reference model of the memory map.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset_;
    logic [11:0] d_mem_addr;
    logic        d_mem_en, d_mem_rd, d_mem_wr;
    logic [7:0]  d_mem_data_out;
    logic [7:0]  d_mem_data_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    dmem_responder #(.RAM_TOP(12'hEFF), .TXF_DEPTH(4)) dut (
        .clk            (clk),
        .reset_         (reset_),
        .d_mem_addr     (d_mem_addr),
        .d_mem_en       (d_mem_en),
        .d_mem_rd       (d_mem_rd),
        .d_mem_wr       (d_mem_wr),
        .d_mem_data_out (d_mem_data_out),
        .d_mem_data_in  (d_mem_data_in),
        .gpio_out       (gpio_out),
        .timer_irq      (timer_irq),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc   = 0;

    // reference model state
    logic [7:0] m_gpio, m_reload, m_count;
    bit         m_en, m_auto, m_pend, m_ovf;
    logic [7:0] q[$];
    logic [7:0] m_ram [4096];
    bit         m_rv  [4096];

    // values sampled at the mid-cycle check point
    logic [7:0] s_rd, s_txd;
    logic       s_irq, s_txv;
    int         s_cyc;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_gpio = '0; m_reload = '0; m_count = '0;
        m_en = 0; m_auto = 0; m_pend = 0; m_ovf = 0;
        q.delete();
    endtask

    function automatic logic [7:0] m_read(input logic [11:0] a);
        int c;
        c = q.size();
        if (a <= 12'hEFF) return m_ram[a];
        case (a)
            12'hF00: return m_gpio;
            12'hF01: return {5'b0, m_pend, m_auto, m_en};
            12'hF02: return m_reload;
            12'hF03: return m_count;
            12'hF05: return {2'b0, c[2:0], m_ovf, c == 0, c == 4};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(input logic [11:0] a, input logic en, input logic wr,
                              input logic [7:0] d, input logic rdy);
        logic [7:0] n_gpio, n_reload, n_count;
        bit n_en, n_auto, n_pend, n_ovf, fired, wen, do_pop, do_push, was_full;
        n_gpio = m_gpio; n_reload = m_reload; n_count = m_count;
        n_en = m_en; n_auto = m_auto; n_ovf = m_ovf;
        wen = en && wr;
        fired = 0;
        if (m_en) begin
            if (m_count != 0) n_count = m_count - 8'd1;
            else begin
                fired = 1;
                if (m_auto) n_count = m_reload;
                else        n_en = 0;
            end
        end
        n_pend = m_pend || fired;
        if (wen) begin
            case (a)
                12'hF00: n_gpio = d;
                12'hF01: begin
                    n_en = d[0]; n_auto = d[1];
                    if (d[2] && !fired) n_pend = 0;
                end
                12'hF02: n_reload = d;
                12'hF03: n_count = d;
                12'hF05: if (d[2]) n_ovf = 0;
                default: ;
            endcase
            if (a <= 12'hEFF) begin
                m_ram[a] = d;
                m_rv[a]  = 1;
            end
        end
        was_full = (q.size() == 4);
        do_push  = wen && (a == 12'hF04);
        do_pop   = (q.size() != 0) && rdy;
        if (do_push && was_full) n_ovf = 1;
        if (do_pop) void'(q.pop_front());
        if (do_push && !was_full) q.push_back(d);
        m_gpio = n_gpio; m_reload = n_reload; m_count = n_count;
        m_en = n_en; m_auto = n_auto; m_pend = n_pend; m_ovf = n_ovf;
    endtask

    // Called just after a rising edge; drives, checks mid-cycle, then steps the model.
    task automatic cycle(input logic [11:0] a, input logic en, input logic rd, input logic wr,
                         input logic [7:0] d, input logic rdy);
        d_mem_addr = a; d_mem_en = en; d_mem_rd = rd; d_mem_wr = wr;
        d_mem_data_out = d; tx_ready = rdy;
        #4;
        s_rd = d_mem_data_in; s_irq = timer_irq; s_txv = tx_valid; s_txd = tx_data; s_cyc = cyc;
        check("gpio_out", gpio_out, m_gpio);
        check("timer_irq", {7'b0, timer_irq}, {7'b0, m_pend});
        check("tx_valid", {7'b0, tx_valid}, {7'b0, q.size() != 0});
        check("tx_data", tx_data, (q.size() != 0) ? q[0] : 8'h00);
        if (en && rd) begin
            if (!(a <= 12'hEFF && !m_rv[a]))
                check($sformatf("rdata@%03h", a), d_mem_data_in, m_read(a));
        end else begin
            check("rdata_idle", d_mem_data_in, 8'h00);
        end
        @(posedge clk);
        cyc++;
        if (reset_) model_step(a, en, wr, d, rdy);
        else        model_reset();
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d, input logic rdy);
        cycle(a, 1'b1, 1'b0, 1'b1, d, rdy);
    endtask

    task automatic rd(input logic [11:0] a, input logic rdy);
        cycle(a, 1'b1, 1'b1, 1'b0, 8'h00, rdy);
    endtask

    task automatic idle(input logic rdy);
        cycle(12'h000, 1'b0, 1'b0, 1'b0, 8'h00, rdy);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fill [5];
        logic [7:0] b;
        logic [11:0] ra [4];
        logic [11:0] a;
        int w, rise1, rise2;

        fill = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        ra   = '{12'h000, 12'h123, 12'hEFF, 12'h7FF};
        foreach (m_rv[i]) m_rv[i] = 0;
        model_reset();
        reset_ = 1'b0;
        d_mem_addr = '0; d_mem_en = 0; d_mem_rd = 0; d_mem_wr = 0;
        d_mem_data_out = '0; tx_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;

        // reset state
        idle(1'b0);
        rd(12'hF01, 1'b0);
        check("rst_tctrl", s_rd, 8'h00);
        rd(12'hF05, 1'b0);
        check("rst_txstat", s_rd, 8'h02);

        // RAM
        wr(12'h123, 8'h5A, 1'b0);
        wr(12'hEFF, 8'hA5, 1'b0);
        rd(12'h123, 1'b0);
        check("ram_123", s_rd, 8'h5A);
        rd(12'hEFF, 1'b0);
        check("ram_eff", s_rd, 8'hA5);
        cycle(12'h123, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("ram_en0", s_rd, 8'h00);

        // GPIO and unmapped MMIO
        wr(12'hF00, 8'h3C, 1'b0);
        idle(1'b0);
        check("gpio_next", gpio_out, 8'h3C);
        rd(12'hF00, 1'b0);
        check("gpio_rd", s_rd, 8'h3C);
        rd(12'hF80, 1'b0);
        check("unmapped", s_rd, 8'h00);

        // timer auto-reload
        wr(12'hF02, 8'd3, 1'b0);
        wr(12'hF03, 8'd3, 1'b0);
        wr(12'hF01, 8'h03, 1'b0);
        w = cyc;
        rise1 = -100;
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            if (s_irq) begin rise1 = s_cyc; break; end
        end
        check("irq_latency", 8'(rise1 - w + 1), 8'd5);
        wr(12'hF01, 8'h07, 1'b0);
        rise2 = -100;
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            if (s_irq) begin rise2 = s_cyc; break; end
        end
        check("irq_period", 8'(rise2 - rise1), 8'd4);

        // one-shot timer
        wr(12'hF03, 8'd2, 1'b0);
        wr(12'hF01, 8'h05, 1'b0);
        repeat (4) idle(1'b0);
        rd(12'hF01, 1'b0);
        check("tctrl_oneshot", s_rd, 8'h04);
        rd(12'hF03, 1'b0);
        check("tcount_oneshot", s_rd, 8'h00);

        // FIFO fill with a stalled sink
        for (int i = 0; i < 5; i++) wr(12'hF04, fill[i], 1'b0);
        rd(12'hF05, 1'b0);
        check("txstat_full", s_rd, 8'h25);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("drain", s_txd, fill[i]);
        end
        idle(1'b1);
        check("drain_empty", {7'b0, s_txv}, 8'h00);
        wr(12'hF05, 8'h04, 1'b0);
        rd(12'hF05, 1'b0);
        check("ovf_clear", s_rd, 8'h02);

        // simultaneous push/pop at count 2, including pointer wrap
        wr(12'hF04, 8'hA1, 1'b0);
        wr(12'hF04, 8'hA2, 1'b0);
        for (int i = 0; i < 10; i++) wr(12'hF04, 8'($urandom), 1'b1);
        rd(12'hF05, 1'b0);
        check("txstat_cnt2", s_rd, 8'h10);
        repeat (3) idle(1'b1);

        // async reset mid-operation
        for (int i = 0; i < 3; i++) wr(12'hF04, 8'h60 + 8'(i), 1'b0);
        wr(12'hF02, 8'd5, 1'b0);
        wr(12'hF03, 8'd5, 1'b0);
        wr(12'hF01, 8'h03, 1'b0);
        repeat (7) idle(1'b0);
        check("pre_rst_irq", {7'b0, s_irq}, 8'h01);
        #2;
        reset_ = 1'b0;
        #1;
        check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_timer_irq", {7'b0, timer_irq}, 8'h00);
        check("rst_gpio", gpio_out, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        idle(1'b0);
        reset_ = 1'b1;
        idle(1'b0);
        rd(12'h123, 1'b0);
        check("ram_kept", s_rd, 8'h5A);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 12'hF00 + 12'($urandom_range(0, 5));
                4:          a = ($urandom_range(0, 1) != 0) ? 12'hF80 : 12'hFFF;
                5:          a = 12'($urandom_range(0, 12'hEFF));
                default:    a = ra[$urandom_range(0, 3)];
            endcase
            b = 8'($urandom);
            if (a == 12'hF03 || a == 12'hF02) b = b & 8'h0F;
            cycle(a, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), b, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Target side of the execute-unit data-memory port. Answers every `d_mem_*` access the execute stage issues:
- Addresses `0x000`–`0xEFF` hit a 3840-byte data RAM.
- Addresses `0xF00`–`0xFFF` hit a memory-mapped I/O page holding a GPIO output register, a down-counting timer with interrupt, and a 4-entry console transmit FIFO drained over a valid/ready handshake.

It sits beside the core, between the execute unit and the board-level I/O.

## Interface
- `RAM_TOP`, `12'hEFF`: last RAM address; addresses above it decode to MMIO.
- `TXF_DEPTH`, `4`: transmit FIFO entries. Must be a power of two, ≤ 8.
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset_` in 1: asynchronous, active-low reset.
- `d_mem_addr` in 12: access address.
- `d_mem_en` in 1: access strobe.
- `d_mem_rd` in 1: read qualifier.
- `d_mem_wr` in 1: write qualifier.
- `d_mem_data_out` in 8: write data, driven by execute.
- `d_mem_data_in` out 8: read data returned to execute.
- `gpio_out` out 8: GPIO register value.
- `timer_irq` out 1: copy of the timer pending bit.
- `tx_valid` out 1: FIFO is not empty.
- `tx_data` out 8: FIFO head byte.
- `tx_ready` in 1: sink accepts the head byte.

## Operation
- Reads: `d_mem_data_in` is combinational from `d_mem_addr` when `d_mem_en & d_mem_rd`, otherwise `8'h00`. Execute consumes it in the same cycle.
- Writes: take effect at the rising edge when `d_mem_en & d_mem_wr`.
- `d_mem_rd & d_mem_wr` together: treated as a write; read data is still returned.
- RAM is not reset; its contents are undefined until written.
- MMIO map (unlisted MMIO addresses read 0 and ignore writes):
  - `0xF00` GPIO: R/W. Drives `gpio_out`.
  - `0xF01` TCTRL: bit0 EN, bit1 AUTO, bit2 PEND.
    - Write: bits 1:0 load directly. A 1 written to bit2 clears PEND; a 0 leaves it.
    - Read: `{5'b0, PEND, AUTO, EN}`.
  - `0xF02` TRELOAD: R/W reload value.
  - `0xF03` TCOUNT: R/W current count.
  - `0xF04` TXDATA: a write pushes the byte. Reads return 0.
  - `0xF05` TXSTAT: read `{2'b0, count[2:0], OVF, EMPTY, FULL}`. A 1 written to bit2 clears OVF.
- Timer, evaluated each cycle while EN=1:
  - COUNT≠0: COUNT ← COUNT−1.
  - COUNT=0: PEND ← 1.
    - If AUTO: COUNT ← RELOAD.
    - Otherwise: EN ← 0 and COUNT stays 0.
  - A CPU write to TCOUNT overrides that cycle's decrement or reload.
  - A PEND clear and a PEND set in the same cycle: set wins.
  - A write to TCTRL setting EN takes effect from the next cycle.
- Transmit FIFO (circular buffer, read/write pointers plus a count):
  - Push: a TXDATA write while count < TXF_DEPTH.
  - Push while full: the byte is dropped and OVF is set (sticky), even if a pop happens the same cycle.
  - Pop: `tx_valid & tx_ready` at the edge.
  - Push and pop together when not full: count unchanged, head advances.
  - Pointers wrap modulo TXF_DEPTH.
  - `tx_data` is the head entry. It is 0 when empty.

## Timing
- Read latency: 0 cycles, combinational. MMIO reads return pre-edge state.
- Write latency: the value is visible on a read or output the cycle after the write edge.
  - `gpio_out` updates at the write edge.
  - A pushed byte reaches `tx_valid`/`tx_data` one cycle after the write.
- Timer period with AUTO=1 and RELOAD=N: PEND sets every N+1 cycles.
- `timer_irq` is registered (it is PEND). It rises the cycle after COUNT is observed at 0 with EN=1.
- Reset values, applied immediately on `reset_` low:
  - `gpio_out` 0, `timer_irq` 0, `tx_valid` 0, `tx_data` 0.
  - TCTRL 0, TRELOAD 0, TCOUNT 0.
  - FIFO empty, pointers 0, OVF 0.
- Reset mid-operation: all MMIO state is discarded, including in-flight FIFO contents. RAM is untouched.
- Handshake rule: `tx_data` and `tx_valid` are held stable while `tx_valid & !tx_ready`.

## Test plan
- RAM read/write: write `0x5A` to `0x123`, `0xA5` to `0xEFF` → subsequent reads return `0x5A` and `0xA5`. With `d_mem_en=0`, `d_mem_data_in` is `0x00`.
- GPIO, TCTRL and unmapped MMIO:
  - Write `0x3C` to `0xF00` → `gpio_out`=`0x3C` next cycle; read returns `0x3C`.
  - Read of `0xF80` returns 0.
- Timer auto-reload: RELOAD=3, COUNT=3, TCTRL=`0x03` → `timer_irq` rises 5 cycles after the TCTRL write edge, and PEND re-sets 4 cycles later.
  - Write `0x07` to TCTRL → PEND clears.
  - AUTO=0: EN reads 0 after expiry.
- FIFO fill with a stalled sink: `tx_ready`=0, push `0x11`,`0x22`,`0x33`,`0x44`,`0x55`:
  - TXSTAT reads FULL=1, count=4, OVF=1.
  - Release `tx_ready` → bytes `0x11`..`0x44` appear in order on consecutive cycles; `0x55` never appears.
- Simultaneous push/pop at count=2 with `tx_ready`=1 → count stays 2 and FIFO order is preserved.
  - Pointer wrap is exercised by 10 continuous push/pop cycles.
- Async reset mid-operation: assert `reset_` low mid-cycle with the FIFO holding 3 entries and the timer running → `tx_valid`, `timer_irq` and `gpio_out` drop to 0 without waiting for a clock edge. The RAM byte at `0x123` is still `0x5A` after reset.
